branch_update_tracker: RTL and testbench
========================================

// Module: branch_update_tracker
// PURPOSE
//  Commit-side writer for the ROB-to-BTB predictor update path. Fetch allocates one entry per predicted
//  control-flow instruction, holding PC, gshare index, predicted direction and predicted target.
//  Execute resolves entries out of order. ROB commit retires them in order.
//  Each retired entry becomes one update packet toward the predictor (valid/ready), with a mispredict flag.
// PARAMETERS
//  DEPTH      16  tracked in-flight control-flow instructions (power of two)
//  TAG_BITS   4   log2(DEPTH)
//  GHR_BITS   8   width of gshare index carried per entry
// PORTS
//  clk               in   1         clock
//  rst               in   1         synchronous, active-low reset
//  alloc_valid       in   1         fetch allocates an entry this cycle
//  alloc_pc          in   32        PC of the control-flow instruction
//  alloc_gshare_idx  in   GHR_BITS  gshare index used at fetch
//  alloc_pred_taken  in   1         fetch-time direction prediction
//  alloc_pred_target in   32        fetch-time predicted next PC
//  alloc_ready       out  1         entry free (count < DEPTH)
//  alloc_tag         out  TAG_BITS  tag assigned to the allocation (= tail pointer)
//  resolve_valid     in   1         execute resolves an entry
//  resolve_tag       in   TAG_BITS  entry being resolved
//  resolve_taken     in   1         actual direction (1 for jal)
//  resolve_target    in   32        actual next PC
//  resolve_is_jal    in   1         1 = jal, 0 = conditional branch
//  commit_valid      in   1         ROB retires oldest tracked instruction
//  commit_ready      out  1         head entry can retire this cycle
//  flush             in   1         squash all uncommitted entries
//  upd_valid         out  1         update packet valid
//  upd_ready         in   1         predictor accepts packet
//  upd_pc            out  32        PC
//  upd_gshare_idx    out  GHR_BITS  gshare index
//  upd_taken         out  1         resolved direction
//  upd_target        out  32        resolved target
//  upd_is_branch     out  1         conditional branch
//  upd_is_jal        out  1         jal
//  upd_mispredict    out  1         prediction differed from resolution
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - head, tail and count = 0; all entries FREE; output register empty.
//   - upd_valid = 0, all upd_* = 0, alloc_ready = 1, alloc_tag = 0, commit_ready = 0.
//  Entry FSM: FREE -alloc-> ALLOC -resolve-> RESOLVED -commit-> FREE. Any state -flush-> FREE (except as below).
//  Alloc:
//   - alloc_valid && alloc_ready writes entry[tail] and sets it ALLOC; tail++ mod DEPTH.
//   - alloc_tag reflects tail combinationally.
//   - Alloc while full is ignored.
//  Resolve:
//   - Accepted only if entry[resolve_tag] is ALLOC; the entry captures taken/target/is_jal and becomes RESOLVED.
//   - Resolve to a FREE or RESOLVED entry is ignored (no state change).
//  Commit:
//   - commit_ready = entry[head] RESOLVED && (output register empty || upd_ready).
//   - commit_valid && commit_ready loads the output register next cycle; entry[head] becomes FREE; head++.
//   - commit_valid without commit_ready is a protocol error: ignored, no state change.
//  Output register:
//   - upd_valid holds until upd_valid && upd_ready. Simultaneous drain and load is allowed (1 packet/cycle).
//   - Latency: 1 cycle from commit to upd_valid.
//  Mispredict: upd_mispredict = (pred_taken != taken) || (taken && pred_target != target). Full 32-bit compare.
//  Count:
//   - count is TAG_BITS+1 wide; +1 on alloc, -1 on commit, unchanged when both occur in one cycle.
//   - Full/empty are decided by count, so head==tail wrap is unambiguous.
//  Flush:
//   - Frees every uncommitted entry: tail <= head, count <= 0.
//   - The output register is NOT cleared; committed updates are always delivered.
//   - Flush+commit in the same cycle: commit takes effect first, then tail <= head+1, count <= 0.
//   - Flush+alloc or flush+resolve in the same cycle: flush wins; alloc and resolve are dropped.
//  Reset mid-operation discards everything, including a pending upd packet.
// TESTING
//  1. Reset; alloc pc=0x100, pred NT; resolve taken, target 0x200; commit.
//     -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, upd_mispredict=1.
//  2. Alloc 16 entries -> alloc_ready=0 after the 16th; a 17th alloc is ignored.
//     Commit one (after resolve) -> alloc_ready=1, alloc_tag=0 (wrap).
//  3. Alloc tags 0,1,2; resolve 2,0,1; commit x3 -> packets emerge in PC order 0,1,2 regardless of resolve order.
//  4. upd_ready=0 with one packet pending -> commit_ready=0 and the held packet stays stable.
//     Raise upd_ready -> packet accepted, the next commit proceeds the same cycle.
//  5. Alloc 4 entries; commit tag0 together with flush
//     -> tag0 packet delivered, count=0, alloc_tag=1; a later resolve to tag 2 is ignored.
//  6. jal pc=0x40, pred taken target 0x80, resolve 0x80 -> upd_is_jal=1, upd_mispredict=0.
//     Repeat with resolve 0x84 -> upd_mispredict=1.

Source files
------------

// File: rtl/branch_update_tracker_if.sv
// Handshake bundle between fetch/execute/commit, the tracker, and the predictor update port.
interface branch_update_tracker_if #(
   parameter int TAG_BITS = 4,
   parameter int GHR_BITS = 8
);
   logic                alloc_valid;
   logic [31:0]         alloc_pc;
   logic [GHR_BITS-1:0] alloc_gshare_idx;
   logic                alloc_pred_taken;
   logic [31:0]         alloc_pred_target;
   logic                alloc_ready;
   logic [TAG_BITS-1:0] alloc_tag;
   logic                resolve_valid;
   logic [TAG_BITS-1:0] resolve_tag;
   logic                resolve_taken;
   logic [31:0]         resolve_target;
   logic                resolve_is_jal;
   logic                commit_valid;
   logic                commit_ready;
   logic                flush;
   logic                upd_valid;
   logic                upd_ready;
   logic [31:0]         upd_pc;
   logic [GHR_BITS-1:0] upd_gshare_idx;
   logic                upd_taken;
   logic [31:0]         upd_target;
   logic                upd_is_branch;
   logic                upd_is_jal;
   logic                upd_mispredict;

   modport master (
      output alloc_valid, alloc_pc, alloc_gshare_idx, alloc_pred_taken, alloc_pred_target,
      input  alloc_ready, alloc_tag,
      output resolve_valid, resolve_tag, resolve_taken, resolve_target, resolve_is_jal,
      output commit_valid,
      input  commit_ready,
      output flush,
      input  upd_valid,
      output upd_ready,
      input  upd_pc, upd_gshare_idx, upd_taken, upd_target, upd_is_branch, upd_is_jal,
      input  upd_mispredict
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_gshare_idx, alloc_pred_taken, alloc_pred_target,
      output alloc_ready, alloc_tag,
      input  resolve_valid, resolve_tag, resolve_taken, resolve_target, resolve_is_jal,
      input  commit_valid,
      output commit_ready,
      input  flush,
      output upd_valid,
      input  upd_ready,
      output upd_pc, upd_gshare_idx, upd_taken, upd_target, upd_is_branch, upd_is_jal,
      output upd_mispredict
   );
endinterface

// File: rtl/branch_update_tracker.sv
// In-order retirement tracker for predicted control-flow instructions; each retired entry
// produces one registered predictor update packet.
module branch_update_tracker #(
   parameter int DEPTH    = 16,
   parameter int TAG_BITS = 4,
   parameter int GHR_BITS = 8
) (
   input  logic clk,
   input  logic rst,
   branch_update_tracker_if.slave bus
);
   typedef enum logic [1:0] {
      ST_FREE     = 2'd0,
      ST_ALLOC    = 2'd1,
      ST_RESOLVED = 2'd2
   } entry_state_t;

   localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS+1)'(DEPTH);

   entry_state_t        r_state       [DEPTH];
   logic [31:0]         r_pc          [DEPTH];
   logic [GHR_BITS-1:0] r_gidx        [DEPTH];
   logic                r_pred_taken  [DEPTH];
   logic [31:0]         r_pred_target [DEPTH];
   logic                r_taken       [DEPTH];
   logic [31:0]         r_target      [DEPTH];
   logic                r_is_jal      [DEPTH];

   logic [TAG_BITS-1:0] r_head;
   logic [TAG_BITS-1:0] r_tail;
   logic [TAG_BITS:0]   r_count;

   logic                r_upd_valid;
   logic [31:0]         r_upd_pc;
   logic [GHR_BITS-1:0] r_upd_gidx;
   logic                r_upd_taken;
   logic [31:0]         r_upd_target;
   logic                r_upd_is_jal;
   logic                r_upd_is_branch;
   logic                r_upd_mispredict;

   logic w_alloc_ready;
   logic w_alloc_fire;
   logic w_resolve_fire;
   logic w_commit_ready;
   logic w_commit_fire;
   logic w_mispredict;

   assign w_alloc_ready  = (r_count < FULL_COUNT);
   // Flush squashes any same-cycle alloc or resolve.
   assign w_alloc_fire   = bus.alloc_valid && w_alloc_ready && !bus.flush;
   assign w_resolve_fire = bus.resolve_valid && (r_state[bus.resolve_tag] == ST_ALLOC) && !bus.flush;
   assign w_commit_ready = (r_state[r_head] == ST_RESOLVED) && (!r_upd_valid || bus.upd_ready);
   assign w_commit_fire  = bus.commit_valid && w_commit_ready;
   assign w_mispredict   = (r_pred_taken[r_head] != r_taken[r_head]) ||
                           (r_taken[r_head] && (r_pred_target[r_head] != r_target[r_head]));

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
      end else begin
         if (w_alloc_fire)   r_state[r_tail]          <= ST_ALLOC;
         if (w_resolve_fire) r_state[bus.resolve_tag] <= ST_RESOLVED;
         if (w_commit_fire)  r_state[r_head]          <= ST_FREE;
      end
   end

   // Payload storage carries no reset; state alone decides validity.
   always_ff @(posedge clk) begin
      if (w_alloc_fire) begin
         r_pc[r_tail]          <= bus.alloc_pc;
         r_gidx[r_tail]        <= bus.alloc_gshare_idx;
         r_pred_taken[r_tail]  <= bus.alloc_pred_taken;
         r_pred_target[r_tail] <= bus.alloc_pred_target;
      end
      if (w_resolve_fire) begin
         r_taken[bus.resolve_tag]  <= bus.resolve_taken;
         r_target[bus.resolve_tag] <= bus.resolve_target;
         r_is_jal[bus.resolve_tag] <= bus.resolve_is_jal;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_commit_fire) r_head <= r_head + 1'b1;
         if (bus.flush) begin
            // Commit is applied before the flush, so the new tail sits past the retired head.
            r_tail  <= w_commit_fire ? r_head + 1'b1 : r_head;
            r_count <= '0;
         end else begin
            if (w_alloc_fire) r_tail <= r_tail + 1'b1;
            if (w_alloc_fire && !w_commit_fire)      r_count <= r_count + 1'b1;
            else if (!w_alloc_fire && w_commit_fire) r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_upd_valid      <= 1'b0;
         r_upd_pc         <= '0;
         r_upd_gidx       <= '0;
         r_upd_taken      <= 1'b0;
         r_upd_target     <= '0;
         r_upd_is_jal     <= 1'b0;
         r_upd_is_branch  <= 1'b0;
         r_upd_mispredict <= 1'b0;
      end else if (w_commit_fire) begin
         r_upd_valid      <= 1'b1;
         r_upd_pc         <= r_pc[r_head];
         r_upd_gidx       <= r_gidx[r_head];
         r_upd_taken      <= r_taken[r_head];
         r_upd_target     <= r_target[r_head];
         r_upd_is_jal     <= r_is_jal[r_head];
         r_upd_is_branch  <= !r_is_jal[r_head];
         r_upd_mispredict <= w_mispredict;
      end else if (r_upd_valid && bus.upd_ready) begin
         r_upd_valid <= 1'b0;
      end
   end

   assign bus.alloc_ready    = w_alloc_ready;
   assign bus.alloc_tag      = r_tail;
   assign bus.commit_ready   = w_commit_ready;
   assign bus.upd_valid      = r_upd_valid;
   assign bus.upd_pc         = r_upd_pc;
   assign bus.upd_gshare_idx = r_upd_gidx;
   assign bus.upd_taken      = r_upd_taken;
   assign bus.upd_target     = r_upd_target;
   assign bus.upd_is_branch  = r_upd_is_branch;
   assign bus.upd_is_jal     = r_upd_is_jal;
   assign bus.upd_mispredict = r_upd_mispredict;
endmodule

// File: tb/tb_branch_update_tracker.sv
// Bench for branch_update_tracker: table of single-entry round trips plus multi-cycle sequences,
// with every delivered update packet checked against a queue of expected packets.
module tb_branch_update_tracker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   branch_update_tracker_if #(.TAG_BITS(4), .GHR_BITS(8)) ifc ();

   branch_update_tracker #(.DEPTH(16), .TAG_BITS(4), .GHR_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  gidx;
      logic        taken;
      logic [31:0] target;
      logic        is_jal;
      logic        mis;
   } pkt_t;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  gidx;
      logic        pt;
      logic [31:0] ptgt;
      logic        taken;
      logic [31:0] tgt;
      logic        jal;
      logic        mis;
   } vec_t;

   pkt_t exp_q[$];
   pkt_t mon_p;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   always @(negedge clk) begin
      if (rst && ifc.upd_valid && ifc.upd_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL upd_unexpected: got pc %0h want no packet", ifc.upd_pc);
         end else begin
            mon_p = exp_q.pop_front();
            chk("upd_pkt",
                {ifc.upd_pc, ifc.upd_gshare_idx, ifc.upd_taken, ifc.upd_target,
                 ifc.upd_is_branch, ifc.upd_is_jal, ifc.upd_mispredict},
                {mon_p.pc, mon_p.gidx, mon_p.taken, mon_p.target,
                 ~mon_p.is_jal, mon_p.is_jal, mon_p.mis});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifc.alloc_valid       = 1'b0;
      ifc.alloc_pc          = '0;
      ifc.alloc_gshare_idx  = '0;
      ifc.alloc_pred_taken  = 1'b0;
      ifc.alloc_pred_target = '0;
      ifc.resolve_valid     = 1'b0;
      ifc.resolve_tag       = '0;
      ifc.resolve_taken     = 1'b0;
      ifc.resolve_target    = '0;
      ifc.resolve_is_jal    = 1'b0;
      ifc.commit_valid      = 1'b0;
      ifc.flush             = 1'b0;
      ifc.upd_ready         = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      cyc();
      cyc();
      chk("rst_upd_valid", ifc.upd_valid, 0);
      chk("rst_alloc_ready", ifc.alloc_ready, 1);
      chk("rst_alloc_tag", ifc.alloc_tag, 0);
      chk("rst_commit_ready", ifc.commit_ready, 0);
      chk("rst_upd_fields", {ifc.upd_pc, ifc.upd_target, ifc.upd_mispredict, ifc.upd_is_jal}, 0);
      exp_q.delete();
      rst = 1'b1;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic [7:0] gidx,
                        input logic pt, input logic [31:0] ptgt);
      ifc.alloc_valid       = 1'b1;
      ifc.alloc_pc          = pc;
      ifc.alloc_gshare_idx  = gidx;
      ifc.alloc_pred_taken  = pt;
      ifc.alloc_pred_target = ptgt;
      cyc();
      ifc.alloc_valid = 1'b0;
   endtask

   task automatic resolve(input logic [3:0] tag, input logic taken,
                          input logic [31:0] tgt, input logic jal);
      ifc.resolve_valid  = 1'b1;
      ifc.resolve_tag    = tag;
      ifc.resolve_taken  = taken;
      ifc.resolve_target = tgt;
      ifc.resolve_is_jal = jal;
      cyc();
      ifc.resolve_valid = 1'b0;
   endtask

   task automatic commit();
      ifc.commit_valid = 1'b1;
      cyc();
      ifc.commit_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic [7:0] gidx, input logic taken,
                       input logic [31:0] tgt, input logic jal, input logic mis);
      pkt_t p;
      p.pc = pc; p.gidx = gidx; p.taken = taken; p.target = tgt; p.is_jal = jal; p.mis = mis;
      exp_q.push_back(p);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        pc            gidx   pt    ptgt          taken tgt           jal   mis
      vecs[0] = '{32'h100,    8'h11, 1'b0, 32'h104,      1'b1, 32'h200,      1'b0, 1'b1};
      vecs[1] = '{32'h40,     8'h22, 1'b1, 32'h80,       1'b1, 32'h80,       1'b1, 1'b0};
      vecs[2] = '{32'h40,     8'h23, 1'b1, 32'h80,       1'b1, 32'h84,       1'b1, 1'b1};
      vecs[3] = '{32'h8f0,    8'h5a, 1'b1, 32'h900,      1'b0, 32'h8f4,      1'b0, 1'b1};
      vecs[4] = '{32'ha00,    8'hc3, 1'b0, 32'h1234,     1'b0, 32'h2000,     1'b0, 1'b0};
      vecs[5] = '{32'hb00,    8'hff, 1'b1, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b1};
      vecs[6] = '{32'hc00,    8'h00, 1'b1, 32'hd00,      1'b1, 32'hd00,      1'b0, 1'b0};

      do_reset();

      // Table: alloc / resolve / commit round trip per vector, 1-cycle latency to upd_valid
      for (int i = 0; i < 7; i++) begin
         chk("tbl_alloc_tag", ifc.alloc_tag, 96'(i));
         alloc(vecs[i].pc, vecs[i].gidx, vecs[i].pt, vecs[i].ptgt);
         resolve(4'(i), vecs[i].taken, vecs[i].tgt, vecs[i].jal);
         chk("tbl_commit_ready", ifc.commit_ready, 1);
         push(vecs[i].pc, vecs[i].gidx, vecs[i].taken, vecs[i].tgt, vecs[i].jal, vecs[i].mis);
         commit();
         chk("tbl_latency", ifc.upd_valid, 1);
      end
      wait_drain();

      // Full table, ignored 17th alloc, wrap
      do_reset();
      for (int i = 0; i < 16; i++) alloc(32'h1000 + 32'(i) * 4, 8'(i), 1'b0, 32'h0);
      chk("full_alloc_ready", ifc.alloc_ready, 0);
      chk("full_alloc_tag", ifc.alloc_tag, 0);
      alloc(32'hdead, 8'hee, 1'b1, 32'hbeef);
      chk("full_17th_tag", ifc.alloc_tag, 0);
      chk("full_17th_ready", ifc.alloc_ready, 0);
      chk("full_head_unresolved", ifc.commit_ready, 0);
      resolve(4'd0, 1'b0, 32'h1004, 1'b0);
      chk("full_commit_ready", ifc.commit_ready, 1);
      push(32'h1000, 8'h00, 1'b0, 32'h1004, 1'b0, 1'b0);
      commit();
      chk("wrap_alloc_ready", ifc.alloc_ready, 1);
      chk("wrap_alloc_tag", ifc.alloc_tag, 0);
      wait_drain();

      // Out-of-order resolve, in-order retirement
      do_reset();
      for (int i = 0; i < 3; i++) begin
         chk("ooo_alloc_tag", ifc.alloc_tag, 96'(i));
         alloc(32'h300 + 32'(i) * 4, 8'h30 + 8'(i), 1'b0, 32'h0);
      end
      resolve(4'd2, 1'b1, 32'h380, 1'b0);
      chk("ooo_head_not_ready", ifc.commit_ready, 0);
      resolve(4'd0, 1'b0, 32'h304, 1'b0);
      resolve(4'd1, 1'b0, 32'h308, 1'b0);
      push(32'h300, 8'h30, 1'b0, 32'h304, 1'b0, 1'b0);
      push(32'h304, 8'h31, 1'b0, 32'h308, 1'b0, 1'b0);
      push(32'h308, 8'h32, 1'b1, 32'h380, 1'b0, 1'b1);
      ifc.commit_valid = 1'b1;
      cyc(); cyc(); cyc();
      ifc.commit_valid = 1'b0;
      wait_drain();

      // Backpressure: held packet stable, commit stalls, then drain+load in one cycle
      do_reset();
      alloc(32'h400, 8'h40, 1'b1, 32'h480);
      alloc(32'h404, 8'h41, 1'b0, 32'h0);
      resolve(4'd0, 1'b1, 32'h480, 1'b0);
      resolve(4'd1, 1'b0, 32'h408, 1'b0);
      ifc.upd_ready = 1'b0;
      push(32'h400, 8'h40, 1'b1, 32'h480, 1'b0, 1'b0);
      commit();
      chk("bp_upd_valid", ifc.upd_valid, 1);
      chk("bp_commit_ready", ifc.commit_ready, 0);
      ifc.commit_valid = 1'b1;
      cyc();
      chk("bp_hold_pc", ifc.upd_pc, 32'h400);
      cyc();
      chk("bp_hold_pc2", ifc.upd_pc, 32'h400);
      chk("bp_still_stalled", ifc.commit_ready, 0);
      ifc.upd_ready = 1'b1;
      #1;
      chk("bp_release_ready", ifc.commit_ready, 1);
      push(32'h404, 8'h41, 1'b0, 32'h408, 1'b0, 1'b0);
      cyc();
      ifc.commit_valid = 1'b0;
      chk("bp_next_pc", ifc.upd_pc, 32'h404);
      chk("bp_next_valid", ifc.upd_valid, 1);
      wait_drain();

      // Flush together with commit of tag 0
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h500 + 32'(i) * 4, 8'h50, 1'b0, 32'h0);
      resolve(4'd0, 1'b0, 32'h504, 1'b0);
      push(32'h500, 8'h50, 1'b0, 32'h504, 1'b0, 1'b0);
      ifc.commit_valid = 1'b1;
      ifc.flush        = 1'b1;
      cyc();
      ifc.commit_valid = 1'b0;
      ifc.flush        = 1'b0;
      chk("fl_upd_valid", ifc.upd_valid, 1);
      chk("fl_alloc_tag", ifc.alloc_tag, 1);
      chk("fl_alloc_ready", ifc.alloc_ready, 1);
      chk("fl_commit_ready", ifc.commit_ready, 0);
      resolve(4'd2, 1'b1, 32'h999, 1'b0);
      resolve(4'd1, 1'b1, 32'h999, 1'b0);
      chk("fl_resolve_free_ignored", ifc.commit_ready, 0);
      ifc.flush = 1'b1;
      alloc(32'h600, 8'h60, 1'b0, 32'h0);
      ifc.flush = 1'b0;
      chk("fl_alloc_dropped", ifc.alloc_tag, 1);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("fl_count_zero", ifc.alloc_ready, 1);
         alloc(32'h700 + 32'(i) * 4, 8'h70, 1'b0, 32'h0);
      end
      chk("fl_refill_full", ifc.alloc_ready, 0);
      wait_drain();

      // Reset with a packet pending discards it
      do_reset();
      alloc(32'h800, 8'h80, 1'b0, 32'h0);
      resolve(4'd0, 1'b1, 32'h900, 1'b0);
      ifc.upd_ready = 1'b0;
      commit();
      chk("mr_pending", ifc.upd_valid, 1);
      do_reset();
      cyc();
      chk("mr_no_packet", ifc.upd_valid, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
